dmem_bridge: RTL
================

Name: dmem_bridge

Overview:
- Responder end of the memory stage's data-memory request channel: accepts m_r_t/m_w_t style requests (byte-enable read/write, address, write data) and runs them on the SRAM-like data bus (req/addr_ok/data_ok).
- Stalls the pipeline while a transaction is outstanding.
- Aligns and sign/zero-extends load data and holds the result until the pipeline advances.
- Sits between the memory stage and the data cache/AXI bridge.

Parameters:
AW, 32, address width
DW, 32, data width (fixed at 32; byte lanes = 4)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_ren  in  4  read byte enables from memory stage (any bit set = load)
req_wen  in  4  write byte strobes, already lane-shifted
req_addr  in  AW  virtual/physical data address
req_wd  in  DW  write data, already lane-shifted
req_ld_size  in  2  00 byte, 01 half, 10 word
req_ld_signed  in  1  1 = sign-extend load result
req_kill  in  1  exception/flush in memory stage; suppresses a new request
pipe_advance  in  1  memory-stage instruction leaves this cycle
stall  out  1  hold memory stage and upstream
rdata  out  DW  formatted load result, valid in DONE
d_req  out  1  bus request
d_wr  out  1  1 = write
d_size  out  2  00 byte, 01 half, 10 word
d_addr  out  AW  bus address
d_wstrb  out  4  write strobes
d_wdata  out  DW  write data
d_addr_ok  in  1  request accepted this cycle
d_data_ok  in  1  read data / write ack this cycle
d_rdata  in  DW  raw read word

Behaviour:
- Reset (async, resetn=0): state IDLE. Latches, rdata, d_* outputs = 0. stall=0.
- new_req = (|req_wen | |req_ren) & ~req_kill.
- If wen is nonzero, the access is a write and ren is ignored.
- IDLE:
  - stall = new_req (combinational, same cycle).
  - On new_req: latch addr, wen, wd, ld_size, ld_signed, is_write; go to REQ.
- REQ:
  - d_req=1; other d_* driven from latches; stall=1.
  - d_addr_ok=1 and d_data_ok=0 → WAIT.
  - d_addr_ok=1 and d_data_ok=1 → DONE, capture data.
  - d_addr_ok=0 → stay in REQ, all d_* held stable.
- WAIT:
  - d_req=0; stall=1.
  - d_data_ok=1 → DONE, capture data.
- DONE:
  - stall=0; rdata held constant.
  - pipe_advance=1 → IDLE.
  - pipe_advance=0 → stay; no reissue.
- d_size:
  - Write: wstrb 1111→10; 0011/1100→01; one-hot→00; any other pattern→10.
  - Read: latched ld_size.
- d_addr = latched addr, unmodified.
- d_wstrb = latched wen on writes, 0 on reads.
- Read formatting (captured on data_ok) uses latched addr[1:0]:
  - Byte: lane addr[1:0].
  - Half: lane addr[1] (addr[0] must be 0).
  - Word: whole d_rdata.
  - Extension per ld_signed.
  - Writes set rdata = 0.
- Minimum latency: request cycle 0, REQ cycle 1 (addr_ok), data_ok cycle 2, DONE cycle 3 (stall low). Total 3 stall cycles.
- req_kill is sampled only in IDLE. Once in REQ, the transaction always runs to DONE, because the bus protocol forbids retracting req before addr_ok.
- Misaligned accesses are excluded upstream via req_kill; the bridge does no alignment check.
- d_data_ok in IDLE or DONE is ignored.
- An async reset mid-transaction abandons it; the downstream is expected to be reset in the same domain.

Test Plan:
- LW: addr 0x8000_0004, d_rdata 0xDEADBEEF, addr_ok in cycle 1, data_ok in cycle 2 → stall high cycles 0–2; rdata = 0xDEADBEEF in cycle 3; d_size=10; d_wr=0.
- LB signed: addr[1:0]=3, d_rdata 0x80FF_0000 → rdata 0xFFFF_FF80. Same access with LBU → 0x0000_0080. LH at addr[1:0]=2 signed → 0xFFFF_80FF.
- SH: wen=1100, wd=0x1234_0000, addr_ok delayed 4 cycles → d_req held with stable addr/wstrb/wdata for 5 cycles; d_size=01; stall releases the cycle after data_ok.
- Kill: req_kill=1 alongside wen=1111 in IDLE → no d_req, stall=0. Kill asserted during WAIT → transaction still completes.
- Hold: DONE with pipe_advance=0 for 3 cycles → rdata stable, no new d_req. pipe_advance=1 → IDLE; a back-to-back request on the next cycle issues normally.
- Reset: resetn=0 during WAIT → immediately IDLE, stall=0, d_req=0, rdata=0.

Source files
------------

// File: rtl/dmem_bridge.sv
// Data-memory request responder: issues loads/stores on the SRAM-like bus,
// stalls the pipe while outstanding and returns an aligned load result.
module dmem_bridge #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [3:0]    req_ren,
    input  logic [3:0]    req_wen,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wd,
    input  logic [1:0]    req_ld_size,
    input  logic          req_ld_signed,
    input  logic          req_kill,
    input  logic          pipe_advance,
    output logic          stall,
    output logic [DW-1:0] rdata,
    output logic          d_req,
    output logic          d_wr,
    output logic [1:0]    d_size,
    output logic [AW-1:0] d_addr,
    output logic [3:0]    d_wstrb,
    output logic [DW-1:0] d_wdata,
    input  logic          d_addr_ok,
    input  logic          d_data_ok,
    input  logic [DW-1:0] d_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    wen_q, wen_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [1:0]    ld_size_q, ld_size_d;
    logic          ld_signed_q, ld_signed_d;
    logic          is_write_q, is_write_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          new_req;

    function automatic logic [DW-1:0] fmt_load(
        input logic [DW-1:0] raw,
        input logic [1:0]    off,
        input logic [1:0]    sz,
        input logic          sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{off, 3'b000} +: 8];
        h = off[1] ? raw[31:16] : raw[15:0];
        case (sz)
            2'b00:   fmt_load = {{24{sgn & b[7]}}, b};
            2'b01:   fmt_load = {{16{sgn & h[15]}}, h};
            default: fmt_load = raw;
        endcase
    endfunction

    assign new_req = ((|req_wen) | (|req_ren)) & ~req_kill;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wen_q       <= '0;
            wd_q        <= '0;
            ld_size_q   <= '0;
            ld_signed_q <= 1'b0;
            is_write_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wd_q        <= wd_d;
            ld_size_q   <= ld_size_d;
            ld_signed_q <= ld_signed_d;
            is_write_q  <= is_write_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wd_d        = wd_q;
        ld_size_d   = ld_size_q;
        ld_signed_d = ld_signed_q;
        is_write_d  = is_write_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (new_req) begin
                    addr_d      = req_addr;
                    wen_d       = req_wen;
                    wd_d        = req_wd;
                    ld_size_d   = req_ld_size;
                    ld_signed_d = req_ld_signed;
                    is_write_d  = |req_wen;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (d_addr_ok) begin
                    state_d = d_data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (d_data_ok) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (pipe_advance) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Load data is captured on the single data_ok that ends the transaction
        if ((state_q == REQ && d_addr_ok && d_data_ok) ||
            (state_q == WAIT && d_data_ok)) begin
            rdata_d = is_write_q ? '0 :
                      fmt_load(d_rdata, addr_q[1:0], ld_size_q, ld_signed_q);
        end
    end

    always_comb begin
        stall = 1'b0;
        d_req = 1'b0;
        unique case (state_q)
            IDLE:    stall = new_req & resetn;
            REQ: begin
                stall = 1'b1;
                d_req = 1'b1;
            end
            WAIT:    stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        d_size = ld_size_q;
        if (is_write_q) begin
            case (wen_q)
                4'b1111:                   d_size = 2'b10;
                4'b0011, 4'b1100:          d_size = 2'b01;
                4'b0001, 4'b0010,
                4'b0100, 4'b1000:          d_size = 2'b00;
                default:                   d_size = 2'b10;
            endcase
        end
    end

    assign d_wr    = is_write_q;
    assign d_addr  = addr_q;
    assign d_wstrb = is_write_q ? wen_q : 4'b0000;
    assign d_wdata = wd_q;
    assign rdata   = rdata_q;

endmodule
